// File: rtl/multicycle_cu_pkg.sv
// Shared opcode, ALU/accumulator control encodings and FSM state type
// for the multi-cycle accumulator CPU control unit.
package multicycle_cu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_CSL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_CLA  = 4'h4;
  localparam logic [3:0] OP_COM  = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'h9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_CSL = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b110;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_CLR  = 2'b01;
  localparam logic [1:0] ACC_COM  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

endpackage

// File: rtl/multicycle_cu_decode.sv
// Combinational opcode decoder: latched opcode to ALU/accumulator controls
// and instruction class flags. Undefined opcodes decode as a flagged nop.
module cu_decode
  import multicycle_cu_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int ALU_CTL_W = 3,
  parameter int ACC_CTL_W = 2
) (
  input  logic [OPCODE_W-1:0]  op,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [ACC_CTL_W-1:0] acc_ctl,
  output logic                 acc_load,
  output logic                 is_mem,
  output logic                 is_store,
  output logic                 is_halt,
  output logic                 illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    alu_ctl  = ALU_CTL_W'(ALU_ADD);
    acc_ctl  = ACC_CTL_W'(ACC_NONE);
    acc_load = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    is_halt  = 1'b0;
    illegal  = 1'b0;
    case (op)
      OPCODE_W'(OP_ADD),
      OPCODE_W'(OP_ADDI): acc_load = 1'b1;
      OPCODE_W'(OP_CSL): begin
        alu_ctl  = ALU_CTL_W'(ALU_CSL);
        acc_load = 1'b1;
      end
      OPCODE_W'(OP_SHR): begin
        alu_ctl  = ALU_CTL_W'(ALU_SHR);
        acc_load = 1'b1;
      end
      OPCODE_W'(OP_CLA): acc_ctl = ACC_CTL_W'(ACC_CLR);
      OPCODE_W'(OP_COM): acc_ctl = ACC_CTL_W'(ACC_COM);
      OPCODE_W'(OP_SW): begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPCODE_W'(OP_LW):  is_mem  = 1'b1;
      OPCODE_W'(OP_HLT): is_halt = 1'b1;
      OPCODE_W'(OP_NOP): ;
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: FETCH->DECODE->EXEC->(MEM)->WB sequencing with
// memory handshakes, halt/resume, sticky error flags and retired-instruction count.
module multicycle_cu
  import multicycle_cu_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int ALU_CTL_W = 3,
  parameter int ACC_CTL_W = 2,
  parameter int MEM_TMO   = 15,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  instr_opcode,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 stall,
  input  logic                 resume,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 dmem_req,
  output logic                 data_rom_write_en,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [ACC_CTL_W-1:0] acc_ctl,
  output logic                 acc_load,
  output logic                 acc_src_mem,
  output logic                 pc_en,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     instr_count
);

  localparam int TMO_W = $clog2(MEM_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q;
  logic [TMO_W-1:0]      wait_q;
  logic                  tmo_hit, ill_set;

  logic [ALU_CTL_W-1:0]  dec_alu;
  logic [ACC_CTL_W-1:0]  dec_acc;
  logic                  dec_load, dec_mem, dec_store, dec_halt, dec_illegal;

  cu_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_CTL_W(ALU_CTL_W),
    .ACC_CTL_W(ACC_CTL_W)
  ) u_decode (
    .op      (op_q),
    .alu_ctl (dec_alu),
    .acc_ctl (dec_acc),
    .acc_load(dec_load),
    .is_mem  (dec_mem),
    .is_store(dec_store),
    .is_halt (dec_halt),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d           = state_q;
    imem_req          = 1'b0;
    ir_load           = 1'b0;
    dmem_req          = 1'b0;
    data_rom_write_en = 1'b0;
    alu_ctl           = ALU_CTL_W'(ALU_ADD);
    acc_ctl           = ACC_CTL_W'(ACC_NONE);
    acc_load          = 1'b0;
    acc_src_mem       = 1'b0;
    pc_en             = 1'b0;
    halted            = 1'b0;
    tmo_hit           = 1'b0;
    ill_set           = 1'b0;
    // Outputs are gated by rst_n so the reset state (FETCH) drives nothing while held.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end else if (wait_q == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = S_HALT;
          end
        end
        S_DECODE: begin
          ill_set = dec_illegal;
          if (!stall) state_d = dec_halt ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          alu_ctl  = dec_alu;
          acc_ctl  = dec_acc;
          acc_load = dec_load;
          state_d  = dec_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          dmem_req          = 1'b1;
          data_rom_write_en = dec_store;
          if (dmem_ack) begin
            acc_load    = !dec_store;
            acc_src_mem = !dec_store;
            state_d     = S_WB;
          end else if (wait_q == TMO_LAST) begin
            tmo_hit = 1'b1;
            state_d = S_HALT;
          end
        end
        S_WB: begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
          if (resume) state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      wait_q      <= '0;
      instr_count <= '0;
      illegal_op  <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      state_q <= state_d;
      if (ir_load) op_q <= instr_opcode;
      // Staying in FETCH/MEM with a request means no ack yet; any state change restarts the count.
      if ((state_d == state_q) && (imem_req || dmem_req)) wait_q <= wait_q + 1'b1;
      else                                                wait_q <= '0;
      if (pc_en)   instr_count <= instr_count + 1'b1;
      if (ill_set) illegal_op  <= 1'b1;
      if (tmo_hit) mem_err     <= 1'b1;
    end
  end

endmodule
